// File: rtl/ip_activate_pkg.sv
// Shared types and constants for the IP activation sequencer.
package ip_activate_pkg;

    localparam int CODE_W = 128;
    localparam int BEAT_W = 32;
    localparam int BEATS  = 4;

    localparam logic [CODE_W-1:0] DEF_REF_CODE =
        128'h87C0D0FD94C369FA1A4B7E7BC00BD074;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        LOCKOUT = 3'd3,
        ACTIVE  = 3'd4,
        DEAD    = 3'd5
    } act_state_t;

endpackage

// File: rtl/act_lockout_timer.sv
// Down-counter for the post-failure lockout window.
// done is high while the count sits at zero.
module act_lockout_timer #(
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic done
);

    localparam int W = $clog2(LOCKOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LOCKOUT_CYCLES - 1);
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ip_activate_ctrl.sv
// Activation sequencer: 4-beat code load, compare, lockout, sticky enable.
// Optional ACT_DEACTIVATE_EN adds a deactivate input that leaves ACTIVE.
module ip_activate_ctrl
    import ip_activate_pkg::*;
#(
    parameter logic [127:0] REF_CODE       = DEF_REF_CODE,
    parameter int           LOCKOUT_CYCLES = 1024,
    parameter int           MAX_FAILS      = 3
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [31:0] code_word,
    input  logic        code_valid,
    output logic        code_ready,
    input  logic        abort,
`ifdef ACT_DEACTIVATE_EN
    input  logic        deactivate,
`endif
    output logic        enable,
    output logic        RDY_enable,
    output logic        busy,
    output logic        locked,
    output logic [3:0]  fail_count
);

    act_state_t        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              enable_q, enable_d;
    logic [3:0]        fail_q, fail_d;
    logic              timer_load;
    logic              timer_done;
    logic              accept;
    logic [3:0]        fail_inc;

    act_lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .load   (timer_load),
        .run    (state_q == LOCKOUT),
        .done   (timer_done)
    );

    assign code_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept     = code_valid && code_ready &&
                        !(abort && state_q == LOAD);
    assign fail_inc   = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        enable_d   = enable_q;
        fail_d     = fail_q;
        timer_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    code_d  = {code_q[CODE_W-BEAT_W-1:0], code_word};
                    cnt_d   = cnt_q + 2'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    code_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    code_d = {code_q[CODE_W-BEAT_W-1:0], code_word};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = CHECK;
                end
            end
            CHECK: begin
                // the secret never outlives its single compare cycle
                code_d = '0;
                if (code_q == REF_CODE) begin
                    enable_d = 1'b1;
                    state_d  = ACTIVE;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == 4'(MAX_FAILS)) begin
                        state_d = DEAD;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = LOCKOUT;
                    end
                end
            end
            LOCKOUT: begin
                if (timer_done) state_d = IDLE;
            end
            ACTIVE: begin
`ifdef ACT_DEACTIVATE_EN
                if (deactivate) begin
                    enable_d = 1'b0;
                    state_d  = IDLE;
                end
`endif
            end
            DEAD: begin
                enable_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            enable_q <= 1'b0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            enable_q <= enable_d;
            fail_q   <= fail_d;
        end
    end

    assign enable     = enable_q;
    assign RDY_enable = (state_q != CHECK);
    assign busy       = (state_q == LOAD) || (state_q == CHECK) ||
                        (state_q == LOCKOUT);
    assign locked     = (state_q == DEAD);
    assign fail_count = fail_q;

endmodule

// File: tb/tb_ip_activate_ctrl.sv
// Scoreboarded bench for ip_activate_ctrl (default parameters).
// Define ACT_DEACTIVATE_EN to also exercise the deactivate path.
module tb_ip_activate_ctrl;

    localparam logic [127:0] GOOD = 128'h87C0D0FD94C369FA1A4B7E7BC00BD074;
    localparam logic [127:0] BAD  = 128'h87C0D0FD94C369FA1A4B7E7BC00BD075;
    localparam int LOCK_CYC = 1024;
    localparam int MAXF     = 3;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] code_word = '0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic        abort = 1'b0;
`ifdef ACT_DEACTIVATE_EN
    logic        deactivate = 1'b0;
`endif
    logic        enable;
    logic        RDY_enable;
    logic        busy;
    logic        locked;
    logic [3:0]  fail_count;

    int checks = 0;
    int errors = 0;
    int m_fail = 0;

    typedef struct {
        logic       en;
        logic [3:0] fc;
        logic       lk;
    } exp_t;

    exp_t sb[$];

    ip_activate_ctrl dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .code_word  (code_word),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .abort      (abort),
`ifdef ACT_DEACTIVATE_EN
        .deactivate (deactivate),
`endif
        .enable     (enable),
        .RDY_enable (RDY_enable),
        .busy       (busy),
        .locked     (locked),
        .fail_count (fail_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_n = 1'b0;
        code_valid = 1'b0;
        abort = 1'b0;
`ifdef ACT_DEACTIVATE_EN
        deactivate = 1'b0;
`endif
        #3;
        rst_n = 1'b1;
        tick();
        m_fail = 0;
        sb.delete();
    endtask

    // Drive 4 beats with valid held; push the model's verdict.
    task automatic send_code(input logic [127:0] c);
        exp_t e;
        logic [127:0] sh;
        sh = c;
        code_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            code_word = sh[127:96];
            sh = sh << 32;
            tick();
        end
        code_valid = 1'b0;
        e.en = (c == GOOD);
        if (!e.en && m_fail < 15) m_fail++;
        e.fc = 4'(m_fail);
        e.lk = !e.en && (m_fail == MAXF);
        sb.push_back(e);
    endtask

    // Entered one cycle after a lockout began; counts remaining busy cycles.
    task automatic wait_lockout(output int n);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (enable !== 1'b0 || RDY_enable !== 1'b1 || busy !== 1'b0 ||
            locked !== 1'b0 || fail_count !== 4'd0 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got en=%0b rdy=%0b busy=%0b lk=%0b fc=%0d cr=%0b want 0 1 0 0 0 1",
                     enable, RDY_enable, busy, locked, fail_count, code_ready);
        end
    endtask

    task automatic test_activate();
        exp_t e;
        do_reset();
        code_valid = 1'b1;
        code_word = 32'h87C0D0FD;
        tick();
        checks++;
        if (code_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL act_beat1 got cr=%0b busy=%0b want 1 1", code_ready, busy);
        end
        code_word = 32'h94C369FA;
        tick();
        code_word = 32'h1A4B7E7B;
        tick();
        code_word = 32'hC00BD074;
        tick();
        code_valid = 1'b0;
        sb.push_back('{en: 1'b1, fc: 4'd0, lk: 1'b0});
        checks++;
        if (code_ready !== 1'b0 || RDY_enable !== 1'b0 || enable !== 1'b0) begin
            errors++;
            $display("FAIL act_check got cr=%0b rdy=%0b en=%0b want 0 0 0",
                     code_ready, RDY_enable, enable);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (enable !== e.en || fail_count !== e.fc || RDY_enable !== 1'b1 ||
            code_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL act_result got en=%0b fc=%0d rdy=%0b cr=%0b busy=%0b want %0b %0d 1 0 0",
                     enable, fail_count, RDY_enable, code_ready, busy, e.en, e.fc);
        end
        code_valid = 1'b1;
        code_word = 32'h87C0D0FD;
        tick();
        code_valid = 1'b0;
        checks++;
        if (enable !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL act_hold got en=%0b busy=%0b want 1 0", enable, busy);
        end
    endtask

    task automatic test_wrong_code();
        exp_t e;
        int n;
        do_reset();
        send_code(BAD);
        tick();
        e = sb.pop_front();
        checks++;
        if (enable !== e.en || fail_count !== e.fc || locked !== e.lk) begin
            errors++;
            $display("FAIL wrong_result got en=%0b fc=%0d lk=%0b want %0b %0d %0b",
                     enable, fail_count, locked, e.en, e.fc, e.lk);
        end
        wait_lockout(n);
        checks++;
        if (n != LOCK_CYC) begin
            errors++;
            $display("FAIL wrong_lockout_len got %0d want %0d", n, LOCK_CYC);
        end
        checks++;
        if (code_ready !== 1'b1 || enable !== 1'b0) begin
            errors++;
            $display("FAIL wrong_after got cr=%0b en=%0b want 1 0", code_ready, enable);
        end
    endtask

    task automatic test_dead();
        exp_t e;
        int n;
        do_reset();
        for (int k = 0; k < MAXF; k++) begin
            send_code(BAD);
            tick();
            e = sb.pop_front();
            checks++;
            if (fail_count !== e.fc || locked !== e.lk || enable !== e.en) begin
                errors++;
                $display("FAIL dead_try%0d got fc=%0d lk=%0b en=%0b want %0d %0b %0b",
                         k, fail_count, locked, enable, e.fc, e.lk, e.en);
            end
            if (!e.lk) begin
                wait_lockout(n);
                checks++;
                if (n != LOCK_CYC) begin
                    errors++;
                    $display("FAIL dead_lockout%0d got %0d want %0d", k, n, LOCK_CYC);
                end
            end
        end
        code_valid = 1'b1;
        code_word = 32'h87C0D0FD;
        for (int i = 0; i < 6; i++) tick();
        code_valid = 1'b0;
        checks++;
        if (locked !== 1'b1 || code_ready !== 1'b0 || busy !== 1'b0 ||
            enable !== 1'b0) begin
            errors++;
            $display("FAIL dead_final got lk=%0b cr=%0b busy=%0b en=%0b want 1 0 0 0",
                     locked, code_ready, busy, enable);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        do_reset();
        code_valid = 1'b1;
        code_word = 32'h87C0D0FD;
        tick();
        code_word = 32'h94C369FA;
        tick();
        code_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle got busy=%0b cr=%0b want 0 1", busy, code_ready);
        end
        code_valid = 1'b1;
        code_word = 32'h87C0D0FD;
        tick();
        code_word = 32'h94C369FA;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        code_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_beat got busy=%0b want 0", busy);
        end
        send_code(GOOD);
        tick();
        e = sb.pop_front();
        checks++;
        if (enable !== e.en || fail_count !== e.fc) begin
            errors++;
            $display("FAIL abort_result got en=%0b fc=%0d want %0b %0d",
                     enable, fail_count, e.en, e.fc);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        send_code(BAD);
        tick();
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1 || fail_count !== e.fc) begin
            errors++;
            $display("FAIL areset_pre got busy=%0b fc=%0d want 1 %0d", busy, fail_count, e.fc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fail_count !== 4'd0 || code_ready !== 1'b1 ||
            RDY_enable !== 1'b1 || enable !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL areset_lockout got busy=%0b fc=%0d cr=%0b rdy=%0b en=%0b lk=%0b want 0 0 1 1 0 0",
                     busy, fail_count, code_ready, RDY_enable, enable, locked);
        end
        rst_n = 1'b1;
        m_fail = 0;
        tick();
        send_code(GOOD);
        tick();
        e = sb.pop_front();
        checks++;
        if (enable !== e.en) begin
            errors++;
            $display("FAIL areset_reactivate got en=%0b want %0b", enable, e.en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (enable !== 1'b0 || code_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_active got en=%0b cr=%0b busy=%0b want 0 1 0",
                     enable, code_ready, busy);
        end
        rst_n = 1'b1;
        m_fail = 0;
        tick();
        send_code(GOOD);
        tick();
        e = sb.pop_front();
        checks++;
        if (enable !== e.en || fail_count !== e.fc) begin
            errors++;
            $display("FAIL areset_final got en=%0b fc=%0d want %0b %0d",
                     enable, fail_count, e.en, e.fc);
        end
    endtask

`ifdef ACT_DEACTIVATE_EN
    task automatic test_deactivate();
        exp_t e;
        do_reset();
        send_code(BAD);
        tick();
        e = sb.pop_front();
        for (int i = 0; i < LOCK_CYC + 2; i++) tick();
        send_code(GOOD);
        tick();
        e = sb.pop_front();
        deactivate = 1'b1;
        tick();
        deactivate = 1'b0;
        checks++;
        if (enable !== 1'b0 || code_ready !== 1'b1 || fail_count !== 4'd1) begin
            errors++;
            $display("FAIL deact got en=%0b cr=%0b fc=%0d want 0 1 1",
                     enable, code_ready, fail_count);
        end
        send_code(GOOD);
        tick();
        e = sb.pop_front();
        checks++;
        if (enable !== e.en) begin
            errors++;
            $display("FAIL deact_reactivate got en=%0b want %0b", enable, e.en);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_activate();
        test_wrong_code();
        test_dead();
        test_abort();
        test_async_reset();
`ifdef ACT_DEACTIVATE_EN
        test_deactivate();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
